// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scanner
// Description : 4x4 hex keypad scanner. Strobes active-low columns, samples
//               synchronized active-low rows once per column dwell,
//               classifies each full scan, debounces over whole scans and
//               shifts accepted hex digits into a 16-bit operand.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
    parameter int SCAN_DIV  = 17,
    parameter int DEB_SCANS = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [3:0]  Row,
    output logic [3:0]  Col,
    input  logic        Clear,
    output logic [3:0]  Key,
    output logic        KeyValid,
    output logic [15:0] Value,
    output logic        Pressed,
    output logic        Multi
);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_CONFIRM = 2'd1;
    localparam logic [1:0] c_ST_HELD    = 2'd2;
    localparam logic [3:0] c_DEB        = 4'(DEB_SCANS);

    logic [3:0]          r_row_meta;
    logic [3:0]          r_row_sync;
    logic [SCAN_DIV-1:0] r_dwell;
    logic [1:0]          r_col_idx;
    logic [1:0]          r_acc_cnt;
    logic [3:0]          r_acc_code;
    logic [1:0]          r_state;
    logic [3:0]          r_cand;
    logic [3:0]          r_cnt;
    logic [3:0]          r_rel;

    logic                w_dwell_last;
    logic                w_scan_end;
    logic [3:0]          w_row_down;
    logic [2:0]          w_col_cnt;
    logic [2:0]          w_sum;
    logic [3:0]          w_first_code;
    logic [1:0]          w_scan_cnt;
    logic [3:0]          w_scan_code;
    logic                w_single;
    logic                w_none;
    logic [1:0]          w_nxt_state;
    logic [3:0]          w_nxt_cand;
    logic [3:0]          w_nxt_cnt;
    logic [3:0]          w_nxt_rel;
    logic                w_accept;

    // Hex code printed on the key at (row, col)
    function automatic logic [3:0] f_key_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'b00_00: code = 4'h1;  4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;  4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;  4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;  4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;  4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;  4'b10_11: code = 4'hC;
            4'b11_00: code = 4'h0;  4'b11_01: code = 4'hF;
            4'b11_10: code = 4'hE;  default:  code = 4'hD;
        endcase
        return code;
    endfunction

    assign Col          = ~(4'b0001 << r_col_idx);
    assign Pressed      = (r_state == c_ST_HELD);
    assign w_dwell_last = &r_dwell;
    assign w_scan_end   = w_dwell_last && (r_col_idx == 2'd3);
    assign w_row_down   = ~r_row_sync;
    assign w_col_cnt    = {2'b00, w_row_down[0]} + {2'b00, w_row_down[1]}
                        + {2'b00, w_row_down[2]} + {2'b00, w_row_down[3]};
    assign w_sum        = {1'b0, r_acc_cnt} + w_col_cnt;
    assign w_scan_cnt   = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
    assign w_scan_code  = (r_acc_cnt == 2'd0) ? w_first_code : r_acc_code;
    assign w_single     = (w_scan_cnt == 2'd1);
    assign w_none       = (w_scan_cnt == 2'd0);

    // Lowest-numbered pressed row in the strobed column gives the first key
    always_comb begin
        w_first_code = 4'h0;
        if (w_row_down[0])      w_first_code = f_key_code(2'd0, r_col_idx);
        else if (w_row_down[1]) w_first_code = f_key_code(2'd1, r_col_idx);
        else if (w_row_down[2]) w_first_code = f_key_code(2'd2, r_col_idx);
        else if (w_row_down[3]) w_first_code = f_key_code(2'd3, r_col_idx);
    end

    // Two-flop synchronizer for the asynchronous row inputs
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_row_meta <= 4'hF;
            r_row_sync <= 4'hF;
        end else begin
            r_row_meta <= Row;
            r_row_sync <= r_row_meta;
        end
    end

    // Dwell counter and column index; the column advances when the dwell wraps
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_dwell   <= '0;
            r_col_idx <= 2'd0;
        end else begin
            r_dwell <= r_dwell + SCAN_DIV'(1);
            if (w_dwell_last) r_col_idx <= r_col_idx + 2'd1;
        end
    end

    // Per-scan accumulator: saturating down-count and first key code, cleared at scan-end
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_acc_cnt  <= 2'd0;
            r_acc_code <= 4'h0;
        end else if (w_dwell_last) begin
            if (w_scan_end) begin
                r_acc_cnt  <= 2'd0;
                r_acc_code <= 4'h0;
            end else begin
                r_acc_cnt  <= w_scan_cnt;
                r_acc_code <= w_scan_code;
            end
        end
    end

    // Debounce next-state logic, evaluated only on scan-end
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cand  = r_cand;
        w_nxt_cnt   = r_cnt;
        w_nxt_rel   = r_rel;
        w_accept    = 1'b0;
        if (w_scan_end) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_single) begin
                        w_nxt_cand = w_scan_code;
                        if (DEB_SCANS == 1) begin
                            w_accept    = 1'b1;
                            w_nxt_state = c_ST_HELD;
                            w_nxt_cnt   = 4'd0;
                            w_nxt_rel   = 4'd0;
                        end else begin
                            w_nxt_state = c_ST_CONFIRM;
                            w_nxt_cnt   = 4'd1;
                        end
                    end
                end
                c_ST_CONFIRM: begin
                    if (w_single && (w_scan_code == r_cand)) begin
                        if ((r_cnt + 4'd1) == c_DEB) begin
                            w_accept    = 1'b1;
                            w_nxt_state = c_ST_HELD;
                            w_nxt_cnt   = 4'd0;
                            w_nxt_rel   = 4'd0;
                        end else begin
                            w_nxt_cnt = r_cnt + 4'd1;
                        end
                    end else begin
                        w_nxt_state = c_ST_IDLE;
                        w_nxt_cnt   = 4'd0;
                    end
                end
                c_ST_HELD: begin
                    if (w_none) begin
                        if ((r_rel + 4'd1) == c_DEB) begin
                            w_nxt_state = c_ST_IDLE;
                            w_nxt_rel   = 4'd0;
                        end else begin
                            w_nxt_rel = r_rel + 4'd1;
                        end
                    end else begin
                        w_nxt_rel = 4'd0;
                    end
                end
                default: begin
                    w_nxt_state = c_ST_IDLE;
                    w_nxt_cnt   = 4'd0;
                    w_nxt_rel   = 4'd0;
                end
            endcase
        end
    end

    // Debounce state registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= c_ST_IDLE;
            r_cand  <= 4'h0;
            r_cnt   <= 4'd0;
            r_rel   <= 4'd0;
        end else begin
            r_state <= w_nxt_state;
            r_cand  <= w_nxt_cand;
            r_cnt   <= w_nxt_cnt;
            r_rel   <= w_nxt_rel;
        end
    end

    // Outputs: accepted key, one-cycle valid pulse, multi-key flag, operand (Clear wins)
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Key      <= 4'h0;
            KeyValid <= 1'b0;
            Value    <= 16'h0000;
            Multi    <= 1'b0;
        end else begin
            KeyValid <= w_accept;
            if (w_accept)   Key   <= w_scan_code;
            if (w_scan_end) Multi <= (w_scan_cnt == 2'd2);
            if (Clear)         Value <= 16'h0000;
            else if (w_accept) Value <= {Value[11:0], w_scan_code};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_scanner
// Description : Directed self-checking bench for keypad_scanner with a
//               combinational 4x4 keypad model (SCAN_DIV=2, DEB_SCANS=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        clear = 1'b0;
    logic [3:0]  key;
    logic        kv;
    logic [15:0] value;
    logic        pressed;
    logic        multi;
    logic [15:0] keys = 16'h0000;   // bit r*4+c set = key (r,c) held

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    keypad_scanner #(.SCAN_DIV(2), .DEB_SCANS(3)) dut (
        .Clk(clk), .Reset(rst), .Row(row), .Col(col), .Clear(clear),
        .Key(key), .KeyValid(kv), .Value(value), .Pressed(pressed), .Multi(multi)
    );

    always #5 clk = ~clk;

    // Keypad model: a held key pulls its row low while its column is strobed
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) row[r] = ~|(keys[r*4 +: 4] & ~col);
    end

    // Count KeyValid pulses on the active edge, away from the negedge checks
    always @(posedge clk) if (kv === 1'b1) pulses <= pulses + 1;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; keys = '0; clear = 1'b0;
        tick(3);
        checks++; if (col !== 4'b1110) begin failures++; $display("FAIL rst_col got=%b exp=1110", col); end
        checks++; if (key !== 4'h0) begin failures++; $display("FAIL rst_key got=%h exp=0", key); end
        checks++; if (kv !== 1'b0) begin failures++; $display("FAIL rst_kv got=%b exp=0", kv); end
        checks++; if (value !== 16'h0) begin failures++; $display("FAIL rst_value got=%h exp=0000", value); end
        checks++; if (pressed !== 1'b0) begin failures++; $display("FAIL rst_pressed got=%b exp=0", pressed); end
        checks++; if (multi !== 1'b0) begin failures++; $display("FAIL rst_multi got=%b exp=0", multi); end
        rst = 1'b0;
        tick(3);
        checks++; if (col !== 4'b1110) begin failures++; $display("FAIL col_c3 got=%b exp=1110", col); end
        tick(1);
        checks++; if (col !== 4'b1101) begin failures++; $display("FAIL col_c4 got=%b exp=1101", col); end
        tick(4);
        checks++; if (col !== 4'b1011) begin failures++; $display("FAIL col_c8 got=%b exp=1011", col); end
        tick(4);
        checks++; if (col !== 4'b0111) begin failures++; $display("FAIL col_c12 got=%b exp=0111", col); end
        tick(4);
        checks++; if (col !== 4'b1110) begin failures++; $display("FAIL col_wrap got=%b exp=1110", col); end
        tick(32);
        checks++; if (multi !== 1'b0) begin failures++; $display("FAIL idle_multi got=%b exp=0", multi); end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL idle_pulses got=%0d exp=0", pulses); end
    endtask

    task automatic test_single_key();
        int p0;
        p0 = pulses;
        keys = 16'h0;
        keys[5] = 1'b1;                      // key (1,1) = 5
        tick(47);
        checks++; if (pressed !== 1'b0) begin failures++; $display("FAIL pre_accept_pressed got=%b exp=0", pressed); end
        checks++; if (kv !== 1'b0) begin failures++; $display("FAIL pre_accept_kv got=%b exp=0", kv); end
        tick(1);
        checks++; if (kv !== 1'b1) begin failures++; $display("FAIL accept_kv got=%b exp=1", kv); end
        checks++; if (key !== 4'h5) begin failures++; $display("FAIL accept_key got=%h exp=5", key); end
        checks++; if (value !== 16'h0005) begin failures++; $display("FAIL accept_value got=%h exp=0005", value); end
        checks++; if (pressed !== 1'b1) begin failures++; $display("FAIL accept_pressed got=%b exp=1", pressed); end
        tick(1);
        checks++; if (kv !== 1'b0) begin failures++; $display("FAIL kv_one_cycle got=%b exp=0", kv); end
        tick(111);
        keys = 16'h0;
        tick(47);
        checks++; if (pressed !== 1'b1) begin failures++; $display("FAIL release_pressed_hold got=%b exp=1", pressed); end
        tick(1);
        checks++; if (pressed !== 1'b0) begin failures++; $display("FAIL release_pressed_fall got=%b exp=0", pressed); end
        tick(32);
        checks++; if (pulses - p0 !== 1) begin failures++; $display("FAIL single_pulses got=%0d exp=1", pulses - p0); end
    endtask

    task automatic test_sequence();
        int ids[5] = '{0, 1, 2, 3, 7};       // keys 1,2,3,A,B
        int p0;
        p0 = pulses;
        for (int i = 0; i < 5; i++) begin
            keys = 16'h0;
            keys[ids[i]] = 1'b1;
            tick(80);
            keys = 16'h0;
            tick(80);
        end
        checks++; if (pulses - p0 !== 5) begin failures++; $display("FAIL seq_pulses got=%0d exp=5", pulses - p0); end
        checks++; if (value !== 16'h23AB) begin failures++; $display("FAIL seq_value got=%h exp=23ab", value); end
        checks++; if (key !== 4'hB) begin failures++; $display("FAIL seq_key got=%h exp=b", key); end
        checks++; if (pressed !== 1'b0) begin failures++; $display("FAIL seq_pressed got=%b exp=0", pressed); end
    endtask

    task automatic test_bounce();
        int p0;
        p0 = pulses;
        keys = 16'h0; keys[12] = 1'b1;       // key (3,0) = 0
        tick(32);
        keys = 16'h0;
        tick(16);
        keys[12] = 1'b1;
        tick(32);
        keys = 16'h0;
        tick(48);
        checks++; if (pulses - p0 !== 0) begin failures++; $display("FAIL bounce_pulses got=%0d exp=0", pulses - p0); end
        checks++; if (value !== 16'h23AB) begin failures++; $display("FAIL bounce_value got=%h exp=23ab", value); end
    endtask

    task automatic test_multi();
        int p0;
        p0 = pulses;
        keys = 16'h0; keys[0] = 1'b1; keys[11] = 1'b1;   // (0,0) and (2,3)
        tick(15);
        checks++; if (multi !== 1'b0) begin failures++; $display("FAIL multi_before got=%b exp=0", multi); end
        tick(1);
        checks++; if (multi !== 1'b1) begin failures++; $display("FAIL multi_first_end got=%b exp=1", multi); end
        tick(80);
        keys = 16'h0;
        checks++; if (multi !== 1'b1) begin failures++; $display("FAIL multi_held got=%b exp=1", multi); end
        tick(16);
        checks++; if (multi !== 1'b0) begin failures++; $display("FAIL multi_clear got=%b exp=0", multi); end
        checks++; if (pulses - p0 !== 0) begin failures++; $display("FAIL multi_pulses got=%0d exp=0", pulses - p0); end
        keys[10] = 1'b1;                     // key (2,2) = 9
        tick(48);
        checks++; if (kv !== 1'b1) begin failures++; $display("FAIL nine_kv got=%b exp=1", kv); end
        checks++; if (key !== 4'h9) begin failures++; $display("FAIL nine_key got=%h exp=9", key); end
        tick(32);
        keys[4] = 1'b1;                      // add key (1,0) = 4
        tick(64);
        checks++; if (multi !== 1'b1) begin failures++; $display("FAIL added_multi got=%b exp=1", multi); end
        keys = 16'h0;
        tick(80);
        checks++; if (pulses - p0 !== 1) begin failures++; $display("FAIL held_pulses got=%0d exp=1", pulses - p0); end
        checks++; if (key !== 4'h9) begin failures++; $display("FAIL held_key got=%h exp=9", key); end
        checks++; if (value !== 16'h3AB9) begin failures++; $display("FAIL held_value got=%h exp=3ab9", value); end
    endtask

    task automatic test_clear_accept();
        int ids[4] = '{0, 1, 2, 4};          // keys 1,2,3,4
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        checks++; if (value !== 16'h0) begin failures++; $display("FAIL clear_value got=%h exp=0000", value); end
        tick(15);
        for (int i = 0; i < 4; i++) begin
            keys = 16'h0;
            keys[ids[i]] = 1'b1;
            tick(80);
            keys = 16'h0;
            tick(80);
        end
        checks++; if (value !== 16'h1234) begin failures++; $display("FAIL pre_clear_value got=%h exp=1234", value); end
        keys[8] = 1'b1;                      // key (2,0) = 7
        tick(47);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        checks++; if (kv !== 1'b1) begin failures++; $display("FAIL clr_acc_kv got=%b exp=1", kv); end
        checks++; if (key !== 4'h7) begin failures++; $display("FAIL clr_acc_key got=%h exp=7", key); end
        checks++; if (value !== 16'h0) begin failures++; $display("FAIL clr_acc_value got=%h exp=0000", value); end
        tick(32);
        keys = 16'h0;
        tick(80);
    endtask

    task automatic test_reset_confirm();
        int p0;
        p0 = pulses;
        keys = 16'h0; keys[9] = 1'b1;        // key (2,1) = 8
        tick(32);
        checks++; if (pressed !== 1'b0) begin failures++; $display("FAIL confirm_pressed got=%b exp=0", pressed); end
        rst = 1'b1;
        keys = 16'h0;
        tick(2);
        checks++; if (col !== 4'b1110) begin failures++; $display("FAIL midrst_col got=%b exp=1110", col); end
        rst = 1'b0;
        tick(80);
        checks++; if (pulses - p0 !== 0) begin failures++; $display("FAIL midrst_pulses got=%0d exp=0", pulses - p0); end
        checks++; if (value !== 16'h0) begin failures++; $display("FAIL midrst_value got=%h exp=0000", value); end
        checks++; if (pressed !== 1'b0) begin failures++; $display("FAIL midrst_pressed got=%b exp=0", pressed); end
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_sequence();
        test_bounce();
        test_multi();
        test_clear_accept();
        test_reset_confirm();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
